// File: rtl/accum_pkg.sv
// Shared constants for the pushbutton accumulator: default widths, board pin
// indices and the operation encoding. Optional feature macro used by this
// design: ACCUM_DEBOUNCE_EN (adds a debounce counter to each key path).
package accum_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ACC_W_DEF    = 9;
    localparam int DEBOUNCE_DEF = 250000;

    // Pushbutton indices on KEY[3:0]
    localparam int KEY_RST = 0;
    localparam int KEY_ACC = 1;
    localparam int KEY_CLR = 3;

    // Switch / LED indices
    localparam int SW_SUB  = 9;
    localparam int LED_OVF = 9;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } accum_op_e;

endpackage

// File: rtl/accum_if.sv
// Board pin bundle for the accumulator: keys, switches and LEDs.
// The board side drives keys/switches and watches the LEDs; the design side
// is the reverse. The top keeps the board pin names as its own ports, so this
// bundle is the harness-side view of the same pins.
interface accum_if;

    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;

    modport board (output key, output sw, input ledr);
    modport dut   (input key, input sw, output ledr);

endinterface

// File: rtl/accum_key_pulse.sv
// key_pulse: turns an active-low pushbutton into a single-cycle press pulse.
// Two-flop synchronizer, then either a plain falling-edge detector or, with
// ACCUM_DEBOUNCE_EN defined, a stable-level debouncer whose high-to-low
// transition produces the pulse. The pulse itself is registered.
module key_pulse #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic press_q;
    logic press_d;

    // Synchronizer; cleared to 0 so a key held low through reset looks
    // already-pressed and produces no pulse when reset releases.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

`ifdef ACCUM_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // Debounced level follows the synchronized key only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; a high-to-low
    // move of the debounced level is the press.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state; level starts low so the key must read high first.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end
`else
    localparam int unused_debounce = DEBOUNCE_CYCLES;

    logic prev_q;

    // Falling edge of the synchronized key; release does nothing.
    always_comb begin
        press_d = prev_q & ~sync2_q;
    end

    // Delayed copy of the synchronized key for edge detection.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync2_q;
        end
    end
`endif

    // Registered press pulse.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            press_q <= 1'b0;
        end else begin
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/accum_top.sv
// accum_top: board-level pushbutton accumulator. KEY[1] adds (or, with SW[9],
// subtracts) SW[7:0]; KEY[3] clears; KEY[0] is the asynchronous reset.
// LEDR[8:0] shows the sum, LEDR[9] a sticky overflow/underflow flag.
// Optional feature macro: ACCUM_DEBOUNCE_EN (debounced key paths).
module accum_top
    import accum_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int ACC_W           = ACC_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR
);

    logic             rst_n;
    logic             acc_press;
    logic             clr_press;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             flag_q;
    logic             flag_d;
    logic [ACC_W:0]   result;
    logic [ACC_W:0]   operand;
    accum_op_e        op;
    logic             unused_inputs;

    assign rst_n         = KEY[KEY_RST];
    assign op            = accum_op_e'(SW[SW_SUB]);
    assign operand       = (ACC_W + 1)'(SW[DATA_W-1:0]);
    assign unused_inputs = ^{KEY[2], SW[8]};

    key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_acc_key (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_n    (KEY[KEY_ACC]),
        .press    (acc_press)
    );

    key_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_key (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_n    (KEY[KEY_CLR]),
        .press    (clr_press)
    );

    // Next accumulator value: the top result bit is the carry or borrow;
    // clear has priority over a same-cycle accumulate.
    always_comb begin
        acc_d  = acc_q;
        flag_d = flag_q;
        result = '0;
        if (clr_press) begin
            acc_d  = '0;
            flag_d = 1'b0;
        end else if (acc_press) begin
            if (op == OP_SUB) begin
                result = {1'b0, acc_q} - operand;
            end else begin
                result = {1'b0, acc_q} + operand;
            end
            acc_d  = result[ACC_W-1:0];
            flag_d = flag_q | result[ACC_W];
        end
    end

    // Accumulator and sticky flag registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            flag_q <= flag_d;
        end
    end

    assign LEDR[LED_OVF]   = flag_q;
    assign LEDR[ACC_W-1:0] = acc_q;

endmodule

// File: tb/tb_accum_top.sv
// Bench for accum_top: directed board scenarios followed by randomized
// add/subtract/clear presses against an integer model of the sum.
module tb_accum_top;

`ifdef ACCUM_DEBOUNCE_EN
    localparam int HOLD_MIN = 8;
`else
    localparam int HOLD_MIN = 3;
`endif

    logic clk;
    int   vectors;
    int   miscompares;
    int   m_acc;
    bit   m_flag;

    accum_if bus ();

    accum_top #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .KEY      (bus.key),
        .SW       (bus.sw),
        .LEDR     (bus.ledr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [9:0] model_led();
        logic [9:0] v;
        v[8:0] = m_acc[8:0];
        v[9]   = m_flag;
        return v;
    endfunction

    task automatic check(input string tag, input logic [9:0] exp_val);
        logic [9:0] obs;
        obs = bus.ledr;
        vectors++;
        assert (obs === exp_val) else begin
            miscompares++;
            $error("FAIL %s: LEDR=%h expected %h", tag, obs, exp_val);
        end
        $display("check %-14s LEDR=%h expected %h", tag, obs, exp_val);
    endtask

    task automatic model_press_acc(input logic [9:0] sw);
        int v;
        if (sw[9]) begin
            v = m_acc - int'(sw[7:0]);
            if (v < 0) begin
                m_flag = 1'b1;
                v += 512;
            end
        end else begin
            v = m_acc + int'(sw[7:0]);
            if (v > 511) begin
                m_flag = 1'b1;
                v -= 512;
            end
        end
        m_acc = v;
    endtask

    task automatic model_clear();
        m_acc  = 0;
        m_flag = 1'b0;
    endtask

    // Press a key for 'hold' cycles, release, then let things settle.
    task automatic press(input int idx, input int hold);
        bus.key[idx] = 1'b0;
        repeat (hold) @(negedge clk);
        bus.key[idx] = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic add_press(input logic [9:0] sw, input int hold, input string tag);
        bus.sw = sw;
        press(1, hold);
        model_press_acc(sw);
        check(tag, model_led());
    endtask

    task automatic clear_press(input string tag);
        press(3, 10);
        model_clear();
        check(tag, model_led());
    endtask

    initial begin
        logic [9:0] sw;
        int hold;
        vectors     = 0;
        miscompares = 0;
        m_acc       = 0;
        m_flag      = 1'b0;
        bus.sw      = 10'h000;
        bus.key     = 4'b1110;

        // 1: reset, then idle
        repeat (3) @(negedge clk);
        check("reset_hold", 10'h000);
        bus.key[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("idle", 10'h000);

        // 2: three adds of 5; the first also checks pulse latency
        bus.sw = 10'd5;
        bus.key[1] = 1'b0;
        repeat (3) @(negedge clk);
`ifndef ACCUM_DEBOUNCE_EN
        check("lat_edge3", 10'h000);
        @(negedge clk);
        check("lat_edge4", 10'd5);
`endif
        repeat (7) @(negedge clk);
        bus.key[1] = 1'b1;
        repeat (12) @(negedge clk);
        model_press_acc(10'd5);
        check("add5_1", model_led());
        add_press(10'd5, 10, "add5_2");
        add_press(10'd5, 10, "add5_3");

        // 3: wrap past 511 sets flag; clear resets both
        clear_press("clr_a");
        add_press(10'd250, 10, "to250");
        add_press(10'd250, 10, "to500");
        add_press(10'd20, 10, "ovf_wrap");
        bus.sw = 10'd0;
        add_press(10'd0, 10, "flag_sticky");
        clear_press("clr_b");

        // 4: borrow
        add_press(10'd3, 10, "to3");
        add_press({1'b1, 1'b0, 8'd5}, 10, "borrow");
        clear_press("clr_c");

        // 5: simultaneous accumulate+clear, then a long hold
        add_press(10'd40, 10, "to40");
        bus.sw = 10'd7;
        bus.key[1] = 1'b0;
        bus.key[3] = 1'b0;
        repeat (10) @(negedge clk);
        bus.key[1] = 1'b1;
        bus.key[3] = 1'b1;
        repeat (12) @(negedge clk);
        model_clear();
        check("clr_wins", model_led());
        bus.key[1] = 1'b0;
        repeat (1000) @(negedge clk);
        model_press_acc(10'd7);
        check("long_hold", model_led());
        bus.key[1] = 1'b1;
        repeat (12) @(negedge clk);
        check("long_release", model_led());

        // 6: reset in the middle of a press
        bus.sw = 10'd9;
        bus.key[1] = 1'b0;
        repeat (2) @(negedge clk);
        #2 bus.key[0] = 1'b0;
        #1 model_clear();
        check("rst_async", model_led());
        repeat (3) @(negedge clk);
        bus.key[0] = 1'b1;
        repeat (10) @(negedge clk);
        bus.key[1] = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_lost", model_led());

`ifdef ACCUM_DEBOUNCE_EN
        // Debounce: short glitch ignored, full press counted once
        bus.sw = 10'd11;
        press(1, 3);
        check("glitch", model_led());
        add_press(10'd11, 6, "deb_press");
`endif

        // Randomized presses, with switch noise afterwards
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                clear_press("rnd_clear");
            end else begin
                sw   = 10'($urandom_range(0, 1023));
                hold = int'($urandom_range(HOLD_MIN, 12));
                add_press(sw, hold, "rnd_press");
            end
            bus.sw = 10'($urandom_range(0, 1023));
            repeat (5) @(negedge clk);
            check("sw_ignored", model_led());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
